// File: rtl/cory_source.sv
// cory_source -- burst data source with a valid/ready handshake toward a sink.
//
// A burst is launched from IDLE by i_start. It then presents i_num words,
// starting at i_seed. Each following word is either the previous word plus one
// (i_mode=0) or a one-bit left-shift LFSR step of it (i_mode=1). After the last
// transfer the block spends one cycle in DONE, pulsing o_done, and then returns
// to IDLE. Every output is registered, so o_v and o_d never depend
// combinationally on i_r.
//
// Optional feature: define CORY_SOURCE_THROTTLE_EN to enable random idle
// insertion. An 8-bit LFSR (x^8+x^6+x^5+x^4+1) holds o_v low at a
// presentation point while lfsr < i_throttle. Without the macro, i_throttle is
// ignored.
//
// Parameters:
//   N  data width in bits (N >= 2)
//   W  transfer-count width in bits
// Ports:
//   clk         clock, rising edge
//   reset       synchronous active-high reset
//   i_start     start a burst (sampled only in IDLE)
//   i_num       burst length, sampled with i_start (0 -> straight to DONE)
//   i_seed      first data word, sampled with i_start
//   i_mode      data pattern: 0 increment, 1 LFSR
//   i_throttle  idle-insertion threshold (throttle build only)
//   o_v / o_d   valid / data toward the sink
//   i_r         ready from the sink; transfer = o_v & i_r at a rising edge
//   o_busy      high while sending
//   o_done      one-cycle pulse at burst end
module cory_source #(
    parameter int N = 64,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_start,
    input  logic [W-1:0] i_num,
    input  logic [N-1:0] i_seed,
    input  logic         i_mode,
    input  logic [7:0]   i_throttle,
    output logic         o_v,
    output logic [N-1:0] o_d,
    input  logic         i_r,
    output logic         o_busy,
    output logic         o_done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   state;
    logic [W-1:0] count;
    logic [W-1:0] num;
    logic         mode;

    // High when a word may be presented at the current presentation point.
    logic present;

`ifdef CORY_SOURCE_THROTTLE_EN
    logic [7:0] lfsr;
    logic       lfsr_fb;

    always_comb lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    always_comb present = (lfsr >= i_throttle);

    always_ff @(posedge clk) begin
        if (reset) lfsr <= 8'hA5;
        else       lfsr <= {lfsr[6:0], lfsr_fb};
    end
`else
    logic unused_throttle;

    always_comb present = 1'b1;
    always_comb unused_throttle = ^i_throttle;
`endif

    function automatic logic [N-1:0] next_word(input logic [N-1:0] d, input logic m);
        if (m) return {d[N-2:0], d[N-1] ^ d[N-2]};
        else   return d + N'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            o_v    <= 1'b0;
            o_d    <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
            count  <= '0;
            num    <= '0;
            mode   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        if (i_num != '0) begin
                            state  <= SEND;
                            o_busy <= 1'b1;
                            o_d    <= i_seed;
                            count  <= '0;
                            num    <= i_num;
                            mode   <= i_mode;
                            o_v    <= present;
                        end else begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (o_v && i_r) begin
                        if (count == num - W'(1)) begin
                            o_v    <= 1'b0;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                            state  <= DONE;
                        end else begin
                            count <= count + W'(1);
                            o_d   <= next_word(o_d, mode);
                            o_v   <= present;
                        end
                    end else if (!o_v) begin
                        // A held-back word keeps retrying; a presented word is never withdrawn.
                        o_v <= present;
                    end
                end
                DONE: begin
                    o_done <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    o_v    <= 1'b0;
                    o_busy <= 1'b0;
                    o_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cory_source.sv
// Testbench for cory_source (N=8, W=8): directed literal checks plus
// randomized traffic, compared every cycle against a queue-based burst model.
module tb_cory_source;

    localparam int N = 8;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         i_start = 1'b0;
    logic [W-1:0] i_num = '0;
    logic [N-1:0] i_seed = '0;
    logic         i_mode = 1'b0;
    logic [7:0]   i_throttle = '0;
    logic         o_v;
    logic [N-1:0] o_d;
    logic         i_r = 1'b0;
    logic         o_busy;
    logic         o_done;

    int n_cmp = 0;
    int n_err = 0;

    cory_source #(.N(N), .W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_start    (i_start),
        .i_num      (i_num),
        .i_seed     (i_seed),
        .i_mode     (i_mode),
        .i_throttle (i_throttle),
        .o_v        (o_v),
        .o_d        (o_d),
        .i_r        (i_r),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The model holds the words still owed to the sink in a queue. Word k of
    // a burst is computed directly from the seed.
    function automatic logic [N-1:0] word_k(input logic [N-1:0] seed, input logic m, input int k);
        logic [N-1:0] w;
        if (!m) return seed + N'(k);
        w = seed;
        for (int j = 0; j < k; j++) w = {w[N-2:0], w[N-1] ^ w[N-2]};
        return w;
    endfunction

    logic [N-1:0] q[$];
    bit           m_ok = 0;
    int           m_phase = 0;   // 0 idle, 1 sending, 2 done
    bit           m_v = 0, m_busy = 0, m_done = 0;
    logic [N-1:0] m_d = '0;
    logic [7:0]   m_lfsr = 8'hA5;

    function automatic bit gate();
`ifdef CORY_SOURCE_THROTTLE_EN
        return m_lfsr >= i_throttle;
`else
        return 1'b1;
`endif
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_ok = 1; m_phase = 0; m_v = 0; m_d = '0; m_busy = 0; m_done = 0;
            q.delete();
            m_lfsr = 8'hA5;
        end else begin
            case (m_phase)
                0: begin
                    m_done = 0;
                    if (i_start) begin
                        if (i_num != 0) begin
                            q.delete();
                            for (int k = 0; k < int'(i_num); k++) q.push_back(word_k(i_seed, i_mode, k));
                            m_phase = 1; m_busy = 1; m_d = q[0]; m_v = gate();
                        end else begin
                            m_phase = 2; m_done = 1;
                        end
                    end
                end
                1: begin
                    if (m_v && i_r) begin
                        void'(q.pop_front());
                        if (q.size() == 0) begin
                            m_v = 0; m_busy = 0; m_done = 1; m_phase = 2;
                        end else begin
                            m_d = q[0]; m_v = gate();
                        end
                    end else if (!m_v) begin
                        m_v = gate();
                    end
                end
                default: begin
                    m_done = 0; m_phase = 0;
                end
            endcase
            m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        end
    end

    // One compare process: outputs are checked against the model every cycle.
    always @(negedge clk) begin
        if (m_ok) begin
            chk("m_o_v", 64'(o_v), 64'(m_v));
            chk("m_o_busy", 64'(o_busy), 64'(m_busy));
            chk("m_o_done", 64'(o_done), 64'(m_done));
            if (m_v) chk("m_o_d", 64'(o_d), 64'(m_d));
        end
    end

    // ---------------- directed stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic start_burst(input logic [N-1:0] seed, input logic [W-1:0] num, input logic m);
        i_seed = seed; i_num = num; i_mode = m; i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic wait_idle();
        int b = 0;
        i_start = 1'b0;
        i_r = 1'b1;
        while ((o_busy || o_done || o_v) && b < 600) begin
            step();
            b++;
        end
        if (b >= 600) chk("idle_timeout", 64'(b), 64'(0));
        step();
    endtask

    initial begin
        int xfers;
        logic [N-1:0] last;

        step(); step(); step();
        chk("rst_o_v", 64'(o_v), 64'(0));
        chk("rst_o_d", 64'(o_d), 64'(0));
        chk("rst_o_busy", 64'(o_busy), 64'(0));
        chk("rst_o_done", 64'(o_done), 64'(0));
        reset = 1'b0;
        step();

        // Back-to-back increment burst.
        i_r = 1'b1;
        start_burst(8'h10, 8'd4, 1'b0);
        chk("b2b_v0", 64'(o_v), 64'(1));
        chk("b2b_busy", 64'(o_busy), 64'(1));
        chk("b2b_d0", 64'(o_d), 64'h10); step();
        chk("b2b_d1", 64'(o_d), 64'h11); step();
        chk("b2b_d2", 64'(o_d), 64'h12); step();
        chk("b2b_d3", 64'(o_d), 64'h13); step();
        chk("b2b_done", 64'(o_done), 64'(1));
        chk("b2b_v_end", 64'(o_v), 64'(0));
        chk("b2b_busy_end", 64'(o_busy), 64'(0));
        step();
        chk("b2b_done_pulse", 64'(o_done), 64'(0));
        wait_idle();

        // Sink stalls for 5 cycles; the word must hold.
        i_r = 1'b0;
        start_burst(8'h5A, 8'd3, 1'b0);
        chk("stall_v", 64'(o_v), 64'(1));
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            chk("stall_hold_v", 64'(o_v), 64'(1));
            chk("stall_hold_d", 64'(o_d), 64'h5A);
        end
        i_r = 1'b1;
        step();
        chk("stall_next_d", 64'(o_d), 64'h5B);
        wait_idle();

        // Increment wraps; LFSR pattern.
        start_burst(8'hFF, 8'd2, 1'b0);
        chk("wrap_d0", 64'(o_d), 64'hFF); step();
        chk("wrap_d1", 64'(o_d), 64'h00);
        wait_idle();
        start_burst(8'h01, 8'd3, 1'b1);
        chk("lfsr_d0", 64'(o_d), 64'h01); step();
        chk("lfsr_d1", 64'(o_d), 64'h02); step();
        chk("lfsr_d2", 64'(o_d), 64'h04);
        wait_idle();

        // Zero-length burst.
        start_burst(8'h33, 8'd0, 1'b0);
        chk("zero_v", 64'(o_v), 64'(0));
        chk("zero_busy", 64'(o_busy), 64'(0));
        chk("zero_done", 64'(o_done), 64'(1));
        step();
        chk("zero_done_pulse", 64'(o_done), 64'(0));
        chk("zero_v2", 64'(o_v), 64'(0));
        wait_idle();

        // Reset mid-burst at count=2 of 8.
        start_burst(8'h20, 8'd8, 1'b0);
        step(); step();
        chk("abort_d2", 64'(o_d), 64'h22);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_v", 64'(o_v), 64'(0));
        chk("abort_d", 64'(o_d), 64'(0));
        chk("abort_busy", 64'(o_busy), 64'(0));
        chk("abort_done", 64'(o_done), 64'(0));
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_no_done", 64'(o_done), 64'(0));
            chk("abort_no_v", 64'(o_v), 64'(0));
        end

        // Maximum-length burst.
        start_burst(8'h03, 8'hFF, 1'b0);
        xfers = 0;
        last = '0;
        for (int b = 0; b < 2000 && !o_done; b++) begin
            if (o_v) begin
                xfers++;
                last = o_d;
            end
            step();
        end
        chk("max_xfers", 64'(xfers), 64'd255);
        chk("max_last", 64'(last), 64'h01);
        chk("max_done", 64'(o_done), 64'(1));
        wait_idle();

`ifdef CORY_SOURCE_THROTTLE_EN
        // Throttled burst with a random sink.
        i_throttle = 8'd128;
        i_seed = 8'h40; i_num = 8'd100; i_mode = 1'b0; i_start = 1'b1;
        xfers = 0;
        for (int b = 0; b < 5000 && !o_done; b++) begin
            i_r = $urandom_range(0, 1) == 1;
            if (b == 1) i_start = 1'b0;
            @(posedge clk);
            if (o_v && i_r) xfers++;
            #2;
        end
        chk("thr_xfers", 64'(xfers), 64'd100);
        chk("thr_done", 64'(o_done), 64'(1));
        wait_idle();
`endif

        // Randomized traffic; i_start is also toggled during SEND and DONE.
        for (int c = 0; c < 4000; c++) begin
            i_start = $urandom_range(0, 3) == 0;
            i_num = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 40)) : W'($urandom_range(0, 9));
            i_seed = N'($urandom);
            i_mode = $urandom_range(0, 1) == 1;
            i_r = $urandom_range(0, 3) != 0;
            i_throttle = 8'($urandom);
            reset = $urandom_range(0, 299) == 0;
            step();
        end
        reset = 1'b0;
        i_throttle = '0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cory_source.md
CORY_SOURCE -- requirements
Module: cory_source

Interface
REQ-001 Parameter: N, 64, data width in bits (N >= 2).
REQ-002 Parameter: W, 16, transfer-count width in bits.
REQ-003 Port: clk  input  1  sole clock; all logic on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: i_start  input  1  start a burst; sampled only in IDLE.
REQ-006 Port: i_num  input  W  transfers in burst; sampled with i_start.
REQ-007 Port: i_seed  input  N  first data word; sampled with i_start.
REQ-008 Port: i_mode  input  1  data pattern: 0 increment, 1 LFSR; sampled with i_start.
REQ-009 Port: i_throttle  input  8  idle-insertion threshold; used only with CORY_SOURCE_THROTTLE_EN.
REQ-010 Port: o_v  output  1  valid toward sink.
REQ-011 Port: o_d  output  N  data toward sink.
REQ-012 Port: i_r  input  1  ready from sink; transfer = o_v & i_r at a rising edge.
REQ-013 Port: o_busy  output  1  high in SEND.
REQ-014 Port: o_done  output  1  one-cycle pulse at burst end.

Function
REQ-015 States: IDLE, SEND, DONE; all outputs registered; o_v/o_d never combinationally depend on i_r.
REQ-016 IDLE: i_start & i_num!=0 -> SEND next cycle, o_d<=i_seed, count<=0; i_start & i_num==0 -> DONE.
REQ-017 SEND: o_busy=1; o_v asserted first cycle in SEND (throttle off); i_start ignored.
REQ-018 Transfer with count<i_num-1: count+1, o_d<=next(o_d), o_v stays 1 (throttle off) -> back-to-back at 1 word/cycle.
REQ-019 Transfer with count==i_num-1: o_v<=0 -> DONE.
REQ-020 DONE: o_done=1 for exactly one cycle, o_v=0, o_busy=0 -> IDLE; i_start in DONE ignored.
REQ-021 Protocol: once o_v=1, o_v and o_d held unchanged until transfer; never withdrawn, never x/z after reset.
REQ-022 next() mode 0: o_d+1 modulo 2^N (all-ones wraps to 0).
REQ-023 next() mode 1: {o_d[N-2:0], o_d[N-1]^o_d[N-2]}; seed 0 yields constant 0 (legal, no error).
REQ-024 count is W bits; i_num=2^W-1 max burst; no overflow.
REQ-025 i_r high while o_v=0 is legal and ignored.

Reset
REQ-026 reset overrides everything, any state: next cycle IDLE, o_v=0, o_d=0, o_busy=0, o_done=0, count=0, throttle LFSR=8'hA5.
REQ-027 Reset mid-burst aborts without o_done; no partial resume.

Configuration
REQ-028 Macro CORY_SOURCE_THROTTLE_EN defined: 8-bit LFSR (x^8+x^6+x^5+x^4+1) advances every clock; at each presentation point (SEND entry or after a non-final transfer) if lfsr<i_throttle, o_v stays 0 and the check repeats next cycle, else o_v<=1.
REQ-029 Throttle never drops o_v already asserted; i_throttle=0 equals no throttle; i_throttle=255 still eventually presents (lfsr=255 reachable).
REQ-030 Macro undefined: no LFSR logic, i_throttle ignored, behaviour per REQ-017/018.

Verification
REQ-031 i_seed=0x10, i_num=4, mode 0, i_r=1 -> o_d 0x10,0x11,0x12,0x13 on 4 consecutive cycles, o_done 1 cycle after last.
REQ-032 i_r=0 for 5 cycles after o_v rises -> o_v=1, o_d=seed stable all 5 cycles; transfer on 6th.
REQ-033 N=8, i_seed=0xFF, i_num=2, mode 0 -> 0xFF then 0x00; mode 1, seed 0x01, i_num=3 -> 0x01,0x02,0x04.
REQ-034 i_num=0 with i_start -> o_v never rises, o_done one cycle later; reset asserted at count=2 of 8 -> o_v=0 next cycle, no o_done.
REQ-035 Throttle build, i_throttle=128, i_num=100, random i_r -> 100 transfers, ordered data, o_v never falls without transfer, o_done once.
